// File: rtl/nrisc_pkg.sv
// Shared nRISC definitions: PC sequencer states
// and default datapath widths for the branch unit.
package nrisc_pkg;

    localparam int PC_WIDTH_D     = 8;
    localparam int OFF_WIDTH_D    = 5;
    localparam int RESET_VECTOR_D = 0;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_HALT   = 2'd3
    } pc_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates: pc+1 and
// pc+sext(offset), both wrapping modulo 2^PC_WIDTH.
module pc_target_calc #(
    parameter int PC_WIDTH  = 8,
    parameter int OFF_WIDTH = 5
) (
    input  logic [PC_WIDTH-1:0]  i_pc,
    input  logic [OFF_WIDTH-1:0] i_offset,
    output logic [PC_WIDTH-1:0]  o_pc_inc,
    output logic [PC_WIDTH-1:0]  o_pc_br
);

    logic [PC_WIDTH-1:0] w_off_sext;

    // Sign-extend the displacement, then add; carries out are dropped.
    always_comb begin
        w_off_sext = {{(PC_WIDTH-OFF_WIDTH){i_offset[OFF_WIDTH-1]}}, i_offset};
        o_pc_inc   = i_pc + PC_WIDTH'(1);
        o_pc_br    = i_pc + w_off_sext;
    end

endmodule

// File: rtl/pc_branch_unit.sv
// PC sequencer and branch resolution: sequential, jump and BEQ
// paths with a one-cycle bubble on redirect and a sticky halt.
module pc_branch_unit
    import nrisc_pkg::*;
#(
    parameter int PC_WIDTH     = PC_WIDTH_D,
    parameter int OFF_WIDTH    = OFF_WIDTH_D,
    parameter int RESET_VECTOR = RESET_VECTOR_D
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 is_jump,
    input  logic                 is_beq,
    input  logic                 is_halt,
    input  logic [OFF_WIDTH-1:0] offset,
    input  logic [PC_WIDTH-1:0]  target_reg,
    input  logic                 cond_atual,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 fetch_valid,
    output logic                 flush,
    output logic                 reset_cond,
    output logic                 halted
);

    pc_state_t           r_state;
    pc_state_t           w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_pc_br;
    logic                w_decide;

    pc_target_calc #(
        .PC_WIDTH (PC_WIDTH),
        .OFF_WIDTH(OFF_WIDTH)
    ) u_calc (
        .i_pc    (r_pc),
        .i_offset(offset),
        .o_pc_inc(w_pc_inc),
        .o_pc_br (w_pc_br)
    );

    // State and PC registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_BOOT;
            r_pc    <= PC_WIDTH'(RESET_VECTOR);
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Next state and next PC; decode only matters in RUN with en.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        unique case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (en) begin
                    if (is_halt) begin
                        w_state_nxt = ST_HALT;
                    end else if (is_jump) begin
                        w_pc_nxt    = target_reg;
                        w_state_nxt = ST_BUBBLE;
                    end else if (is_beq && cond_atual) begin
                        w_pc_nxt    = w_pc_br;
                        w_state_nxt = ST_BUBBLE;
                    end else begin
                        w_pc_nxt    = w_pc_inc;
                    end
                end
            end
            ST_BUBBLE: begin
                if (en) w_state_nxt = ST_RUN;
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // Output decode; the pulses are suppressed while reset is asserted.
    always_comb begin
        w_decide    = reset && en && (r_state == ST_RUN) && !is_halt;
        flush       = w_decide && (is_jump || (is_beq && cond_atual));
        reset_cond  = w_decide && !is_jump && is_beq;
        fetch_valid = (r_state == ST_RUN);
        halted      = (r_state == ST_HALT);
        pc          = r_pc;
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed scenarios then random
// stimulus, all checked against a behavioural PC model.
module tb_pc_branch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       is_jump;
    logic       is_beq;
    logic       is_halt;
    logic [4:0] offset;
    logic [7:0] target_reg;
    logic       cond_atual;
    logic [7:0] pc;
    logic       fetch_valid;
    logic       flush;
    logic       reset_cond;
    logic       halted;

    int checks = 0;
    int errors = 0;

    // Model: mode 0=boot 1=run 2=bubble 3=halt, plain integer PC.
    int m_mode;
    int m_pc;

    pc_branch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .is_jump    (is_jump),
        .is_beq     (is_beq),
        .is_halt    (is_halt),
        .offset     (offset),
        .target_reg (target_reg),
        .cond_atual (cond_atual),
        .pc         (pc),
        .fetch_valid(fetch_valid),
        .flush      (flush),
        .reset_cond (reset_cond),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sext5(input logic [4:0] o);
        return o[4] ? int'(o) - 32 : int'(o);
    endfunction

    task automatic idle();
        reset = 1'b1; en = 1'b1;
        is_jump = 1'b0; is_beq = 1'b0; is_halt = 1'b0;
        offset = 5'd0; target_reg = 8'd0; cond_atual = 1'b0;
    endtask

    // Inputs are set at the falling edge; check, clock, update model.
    task automatic step();
        bit act;
        int e_flush;
        int e_rc;
        #1;
        act = reset && en && (m_mode == 1) && !is_halt;
        e_flush = (act && (is_jump || (is_beq && cond_atual))) ? 1 : 0;
        e_rc = (act && !is_jump && is_beq) ? 1 : 0;
        chk("pc", 32'(pc), 32'(m_pc));
        chk("fetch_valid", 32'(fetch_valid), (m_mode == 1) ? 1 : 0);
        chk("halted", 32'(halted), (m_mode == 3) ? 1 : 0);
        chk("flush", 32'(flush), 32'(e_flush));
        chk("reset_cond", 32'(reset_cond), 32'(e_rc));
        @(posedge clk);
        if (!reset) begin
            m_mode = 0;
            m_pc = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1 && en) begin
            if (is_halt) m_mode = 3;
            else if (is_jump) begin
                m_pc = int'(target_reg);
                m_mode = 2;
            end else if (is_beq && cond_atual) begin
                m_pc = (m_pc + sext5(offset)) & 255;
                m_mode = 2;
            end else begin
                m_pc = (m_pc + 1) & 255;
            end
        end else if (m_mode == 2 && en) begin
            m_mode = 1;
        end
        @(negedge clk);
    endtask

    task automatic jump_to(input logic [7:0] t);
        idle(); is_jump = 1'b1; target_reg = t;
        step();
        idle();
        step();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_mode = 0;
        m_pc = 0;

        // Boot then four sequential fetches.
        idle();
        step();
        chk("boot_pc", 32'(pc), 32'h0);
        for (int i = 0; i < 4; i++) step();
        chk("seq_pc4", 32'(pc), 32'h4);

        // Taken BEQ backwards from 0x10.
        jump_to(8'h10);
        chk("at_10", 32'(pc), 32'h10);
        is_beq = 1'b1; cond_atual = 1'b1; offset = 5'b11110;
        #1;
        chk("beq_t_flush", 32'(flush), 32'h1);
        chk("beq_t_rc", 32'(reset_cond), 32'h1);
        step();
        idle();
        chk("beq_t_pc", 32'(pc), 32'h0E);
        chk("beq_t_bubble", 32'(fetch_valid), 32'h0);
        step();
        chk("beq_t_run", 32'(fetch_valid), 32'h1);

        // Not-taken BEQ: no bubble.
        jump_to(8'h10);
        is_beq = 1'b1; cond_atual = 1'b0; offset = 5'b11110;
        step();
        idle();
        chk("beq_nt_pc", 32'(pc), 32'h11);
        chk("beq_nt_fv", 32'(fetch_valid), 32'h1);

        // Jump wins over BEQ; stall inside the bubble.
        is_jump = 1'b1; is_beq = 1'b1; cond_atual = 1'b1;
        target_reg = 8'h40;
        #1;
        chk("jb_rc", 32'(reset_cond), 32'h0);
        step();
        idle();
        en = 1'b0;
        is_jump = 1'b1; target_reg = 8'h99;
        step();
        step();
        chk("jb_stall_pc", 32'(pc), 32'h40);
        chk("jb_stall_fv", 32'(fetch_valid), 32'h0);
        idle();
        step();
        chk("jb_run", 32'(fetch_valid), 32'h1);

        // Wrap up and down.
        jump_to(8'hFF);
        step();
        chk("wrap_up", 32'(pc), 32'h00);
        jump_to(8'h01);
        is_beq = 1'b1; cond_atual = 1'b1; offset = 5'b11110;
        step();
        idle();
        chk("wrap_dn", 32'(pc), 32'hFF);
        step();

        // Halt at 0x07 with further branches; then reset.
        jump_to(8'h07);
        is_halt = 1'b1;
        step();
        idle();
        is_jump = 1'b1; is_beq = 1'b1; cond_atual = 1'b1;
        target_reg = 8'h55;
        for (int i = 0; i < 3; i++) step();
        chk("halt_pc", 32'(pc), 32'h07);
        chk("halt_flag", 32'(halted), 32'h1);
        reset = 1'b0;
        step();
        idle();
        chk("halt_rst_pc", 32'(pc), 32'h0);
        chk("halt_rst_flag", 32'(halted), 32'h0);

        // Random stimulus against the model.
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(0, 79) != 0);
            en         = ($urandom_range(0, 3) != 0);
            is_jump    = ($urandom_range(0, 5) == 0);
            is_beq     = ($urandom_range(0, 2) == 0);
            is_halt    = ($urandom_range(0, 49) == 0);
            offset     = 5'($urandom);
            target_reg = 8'($urandom);
            cond_atual = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

- Program-counter and branch-resolution stage of the nRISC core.
- Sits directly downstream of the COND flag register:
  - consumes its registered flag `cond_atual`;
  - drives the `reset_cond` clear back into it.
- Sequences the PC through sequential, jump and BEQ paths.
- Inserts a one-cycle fetch bubble on every redirect and latches a halt state.

## Interface
Parameters:
- `PC_WIDTH`, 8: width of the PC and jump target.
- `OFF_WIDTH`, 5: width of the signed BEQ offset.
- `RESET_VECTOR`, 0: PC value after reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `en`  in  1  advance enable (0 = pipeline stall).
- `is_jump`  in  1  decoded unconditional jump.
- `is_beq`  in  1  decoded conditional branch.
- `is_halt`  in  1  decoded halt.
- `offset`  in  OFF_WIDTH  signed BEQ displacement, relative to the current `pc`.
- `target_reg`  in  PC_WIDTH  absolute jump target, from the register file.
- `cond_atual`  in  1  current COND flag.
- `pc`  out  PC_WIDTH  current fetch address (registered).
- `fetch_valid`  out  1  the instruction at `pc` is valid this cycle.
- `flush`  out  1  kill the wrong-path instruction; combinational pulse.
- `reset_cond`  out  1  clear COND at this edge; combinational pulse.
- `halted`  out  1  core halted (registered).

## Operation
- States: BOOT, RUN, BUBBLE, HALT.
- Reset (`reset`=0 at an edge) applies regardless of state:
  - `pc`=RESET_VECTOR, state=BOOT, `halted`=0.
  - `fetch_valid`=0; `flush`=0 and `reset_cond`=0 are combinational zero.
  - Reset mid-branch or mid-bubble discards everything.
- BOOT: `fetch_valid`=0, then unconditionally goes to RUN next cycle; `pc` is not incremented.
- RUN: `fetch_valid`=1. The following apply only when `en`=1, in priority order:
  1. `is_halt`: `pc` holds → HALT; `halted`=1 from the next cycle.
  2. `is_jump`: `pc`←`target_reg`; `flush`=1 → BUBBLE. `reset_cond`=0, even if `is_beq` is also set.
  3. `is_beq`: `reset_cond`=1, taken or not.
     - `cond_atual`=1: `pc`←`pc`+sext(`offset`); `flush`=1 → BUBBLE.
     - `cond_atual`=0: `pc`←`pc`+1; stay in RUN.
  4. None of the above: `pc`←`pc`+1.
- RUN with `en`=0: `pc` holds; `flush`=0 and `reset_cond`=0; decode inputs are ignored.
- BUBBLE: `fetch_valid`=0; decode inputs are ignored; `flush`=0 and `reset_cond`=0.
  - `en`=1 → RUN; `en`=0 → stay in BUBBLE.
- HALT: `fetch_valid`=0, `halted`=1, `pc` frozen. Exits only via reset.
- Arithmetic:
  - All PC arithmetic is modulo 2^PC_WIDTH.
  - `offset` is sign-extended to PC_WIDTH before the add.
  - Overflow and underflow wrap silently, e.g. 0xFF+1=0x00 and 0x01+(−2)=0xFF.
- `cond_atual` is sampled only in the BEQ cycle. COND clears at the same edge the branch retires.

## Timing
- Sequential instruction: 1 cycle per `pc` step.
- Taken branch or jump:
  - `flush` is high in the decision cycle.
  - The new `pc` is visible after the edge.
  - `fetch_valid`=0 for exactly 1 cycle (BUBBLE), assuming `en`=1.
  - Penalty: 1 cycle.
- Not-taken BEQ: 0 penalty.
- `reset_cond` and `flush` are valid only while `en`=1 in RUN. They are never asserted in BOOT, BUBBLE or HALT.
- After reset is released: first cycle is BOOT; `fetch_valid`=1 from the second cycle with `pc`=RESET_VECTOR.

## Structure
- Shared package `nrisc_pkg`: the state enum (BOOT/RUN/BUBBLE/HALT) and the default PC_WIDTH/OFF_WIDTH/RESET_VECTOR constants.
- One sub-module, `pc_target_calc`, which is combinational. It produces `pc`+1 and `pc`+sext(`offset`) with wrap.
- Top level holds the state register, the PC register and the output decode.

## Test plan
- Reset, then 4 cycles with `en`=1 and no branches:
  - BOOT cycle with `fetch_valid`=0;
  - then `pc` = 0, 1, 2, 3 with `fetch_valid`=1.
- `pc`=0x10, `is_beq`=1, `cond_atual`=1, `offset`=5'b11110:
  - `reset_cond`=1 and `flush`=1 that cycle;
  - `pc`=0x0E next, `fetch_valid`=0 for 1 cycle, then RUN.
- `pc`=0x10, `is_beq`=1, `cond_atual`=0:
  - `reset_cond`=1, `flush`=0;
  - `pc`=0x11 with no bubble.
- `is_jump`=1 and `is_beq`=1 together with `target_reg`=0x40, then `en`=0 during BUBBLE for 2 cycles:
  - `pc`=0x40, `reset_cond`=0;
  - stays in BUBBLE while `en`=0, returns to RUN on the first `en`=1.
- `pc`=0xFF sequential, then `pc`=0x01 with a taken BEQ and `offset`=−2:
  - wraps to 0x00;
  - then reaches 0xFF.
- `is_halt` at `pc`=0x07, with further branch stimulus:
  - `halted`=1, `pc` frozen at 0x07, `fetch_valid`=0;
  - assert `reset`=0 mid-HALT → `pc`=RESET_VECTOR, `halted`=0.
